// File: rtl/p2s_serializer_8b_if.sv
// Byte handshake between the upstream 4:1 mux and the serializer.
// The mux presents data_in/valid_in; the serializer raises load_req on the cycle it samples them.
interface p2s_serializer_8b_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       load_req;

    modport master (
        output data_in,
        output valid_in,
        input  load_req
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output load_req
    );
endinterface

// File: rtl/p2s_serializer_8b.sv
// MSB-first 8:1 serializer with a post-reset burst of idle/comma bytes for receiver alignment.
// Invalid bytes at a load boundary are replaced by IDLE_CHAR so the serial stream never has gaps.
module p2s_serializer_8b #(
    parameter logic [7:0] IDLE_CHAR  = 8'hBC,
    parameter int         SYNC_BYTES = 4
) (
    input  logic                       clk_32f,
    input  logic                       reset,
    p2s_serializer_8b_if.slave         bus,
    output logic                       data_out,
    output logic                       byte_start,
    output logic                       byte_active,
    output logic                       sync_done
);

    typedef enum logic {
        SYNC,
        ACTIVE
    } state_t;

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_BYTES - 1);

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] sh_q;
    logic [7:0] sync_cnt_q;
    logic       data_out_q;
    logic       byte_start_q;
    logic       byte_active_q;
    logic       sync_done_q;

    logic [7:0] byte_d;
    logic       take_data_d;

    // Byte chosen at a load boundary: real data only once aligned and flagged valid.
    always_comb begin
        take_data_d = (state_q == ACTIVE) && bus.valid_in;
        byte_d      = take_data_d ? bus.data_in : IDLE_CHAR;
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q       <= SYNC;
            bit_cnt_q     <= 3'd0;
            sh_q          <= 8'd0;
            sync_cnt_q    <= 8'd0;
            data_out_q    <= 1'b0;
            byte_start_q  <= 1'b0;
            byte_active_q <= 1'b0;
            sync_done_q   <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd0) begin
                sh_q          <= byte_d;
                data_out_q    <= byte_d[7];
                byte_start_q  <= 1'b1;
                byte_active_q <= take_data_d;
                if (state_q == SYNC) begin
                    sync_cnt_q <= sync_cnt_q + 8'd1;
                    if (sync_cnt_q == SYNC_LAST) begin
                        state_q     <= ACTIVE;
                        sync_done_q <= 1'b1;
                    end
                end
            end else begin
                // 3'd7 - k selects bits 6..0 for k = 1..7.
                data_out_q   <= sh_q[3'd7 - bit_cnt_q];
                byte_start_q <= 1'b0;
            end
        end
    end

    assign bus.load_req = (bit_cnt_q == 3'd0) && (state_q == ACTIVE) && !reset;
    assign data_out     = data_out_q;
    assign byte_start   = byte_start_q;
    assign byte_active  = byte_active_q;
    assign sync_done    = sync_done_q;

endmodule
